mdio_phy_responder: RTL
=======================

# mdio_phy_responder

PHY-side Clause 22 MDIO management responder: the far end of the TSE MAC's MDIO master (`mdc`, `mdio_out`, `mdio_oen`, `mdio_in`). It lets the FPGA present an emulated PHY register space on the management bus, for loopback and bring-up of the MAC driver stack without a real PHY. It decodes read and write frames addressed to its PHY address. Writes are forwarded to user logic as single-cycle pulses; read data is fetched from user logic and shifted back to the master.

## Interface

Parameters:
- `PHY_ADDR`, 5'd1: PHY address this responder answers to.
- `BROADCAST_EN`, 0: when 1, write frames to PHYAD 0 are also accepted. Reads to PHYAD 0 are never answered.
- `PREAMBLE_MIN`, 32: consecutive 1 bits required before a start-of-frame is recognised (1..32).

Ports:
- `clk_clk`, in, 1: system clock. Must be at least 8× the MDC frequency.
- `reset_reset_n`, in, 1: asynchronous, active-low reset.
- `mdc`, in, 1: management clock from the master. Asynchronous to `clk_clk`.
- `mdio_in`, in, 1: MDIO pad input.
- `mdio_out`, out, 1: MDIO value driven by the responder.
- `mdio_oen`, out, 1: output enable, active-low. 0 = drive `mdio_out`, 1 = tri-state.
- `reg_addr`, out, 5: register address of the current frame.
- `reg_rd`, out, 1: one-clk pulse requesting read data for `reg_addr`.
- `reg_rdata`, in, 16: read data, sampled exactly 1 clk after `reg_rd`.
- `reg_wr`, out, 1: one-clk pulse; `reg_addr`/`reg_wdata` are valid on that cycle.
- `reg_wdata`, out, 16: write data.

## Operation

Input conditioning and edge detection:
- `mdc` and `mdio_in` each pass through a 2-flop synchroniser. A third register on synchronised `mdc` provides edge detection.
- On an MDC rise, `mdio_in` is sampled.
- On an MDC fall, `mdio_out`/`mdio_oen` are updated.

FSM states: PRE, ST, OP, PHYAD, REGAD, TA, DATA.
- PRE: a saturating counter (0..PREAMBLE_MIN) counts sampled 1s. A sampled 0 with count < PREAMBLE_MIN clears the count. A sampled 0 with count == PREAMBLE_MIN is ST bit 0 → ST.
- ST: next bit must be 1 → OP. If it is 0 → PRE with count cleared.
- OP: 2 bits, MSB first. 10 = read, 01 = write. 00 and 11 are not answered; the frame is run to completion silently.
- PHYAD: 5 bits, MSB first. Match = (PHYAD == PHY_ADDR), or (BROADCAST_EN and PHYAD == 0 and write).
- REGAD: 5 bits, MSB first. On the last REGAD rise, `reg_addr` is loaded. If (read and match), `reg_rd` pulses and `reg_rdata` is latched into the shift register 1 clk later.
- TA: 2 bit times.
  - Read+match: on the MDC fall ending the first TA bit, `mdio_oen` = 0 and `mdio_out` = 0.
  - Otherwise the bus stays released and TA values are ignored.
- DATA: 16 bits.
  - Read+match: on each MDC fall, shift out the next bit, MSB first. After the fall that follows the 16th data bit, `mdio_oen` = 1 → PRE.
  - Write+match: shift in on each rise. On the 16th rise, load `reg_wdata` and pulse `reg_wr` → PRE.
  - No match / invalid OP: count 16 bits → PRE.
- The preamble count is cleared on every return to PRE; each frame needs a full preamble.

Bus safety:
- `mdio_oen` is 0 only during TA bit 2 and DATA of a matched read.

## Timing

- Reset values: `mdio_out` = 0, `mdio_oen` = 1, `reg_addr` = 0, `reg_wdata` = 0, `reg_rd` = 0, `reg_wr` = 0. FSM resets to PRE with count 0.
- Edge recognition: an MDC pin edge is acted upon 3 clk after it occurs (2 sync + 1 edge register). Output update follows on the next clk edge.
- `reg_rd` occurs ≥ 2 MDC periods before the first data bit is driven.
- `reg_wr` fires 1 clk after the 16th write-data rise is detected.
- `reg_wr` and `reg_rd` are never asserted together and never more than once per frame.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronously), so the bus is released. After reset, the next frame requires a full preamble.
- Master aborts mid-frame by restarting the preamble: the current frame runs to its bit count, then PRE hunting resumes. No resynchronisation is attempted in between.

## Test plan

- Read frame: 32×1, ST 01, OP 10, PHYAD 1, REGAD 0x02, reg_rdata = 0x1234 → `reg_rd` pulses once with `reg_addr` = 0x02. TA is Z then 0. Serial data is 0001_0010_0011_0100. `mdio_oen` returns to 1 after the last bit.
- Write frame to PHYAD 1, REGAD 0x00, data 0x8140 → exactly one `reg_wr` with `reg_addr` = 0x00, `reg_wdata` = 0x8140. `mdio_oen` stays 1 throughout.
- Read frame with PHYAD 5 → no `reg_rd`, `mdio_oen` stays 1. A following valid read to PHYAD 1 is answered correctly.
- Preamble of 31 ones then a valid frame with PREAMBLE_MIN = 32 → no response. Repeated with 32 ones → response.
- BROADCAST_EN = 1: write to PHYAD 0 → `reg_wr` fires. Read to PHYAD 0 → no drive.
- Assert `reset_reset_n` low during DATA of a matched read → `mdio_oen` = 1 immediately. After release, a new full frame is answered.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: presents an emulated PHY register space
// to an MDIO master. Writes leave as single-cycle pulses, reads are fetched
// from user logic and shifted back onto the bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// PRE     | hunting for preamble ones followed by ST bit 0
// ST      | expecting ST bit 1
// OP      | shifting in the 2-bit opcode
// PHYAD   | shifting in the PHY address, match decided on the last bit
// REGAD   | shifting in the register address, read request on last bit
// TA      | turnaround, responder takes the bus for a matched read
// DATA    | 16 data bits, shifted out (read) or in (write) or skipped
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter bit         BROADCAST_EN = 1'b0,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata
);

    localparam logic [2:0] S_PRE   = 3'd0;
    localparam logic [2:0] S_ST    = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_DATA  = 3'd6;

    localparam logic [5:0] L_PRE_MIN = 6'(PREAMBLE_MIN);

    logic        r_mdc_s1, r_mdc_s2, r_mdc_d;
    logic        r_mdio_s1, r_mdio_s2;
    logic [2:0]  r_state;
    logic [5:0]  r_pre_cnt;
    logic [4:0]  r_bit_cnt;
    logic [1:0]  r_op;
    logic [3:0]  r_phyad;
    logic [3:0]  r_regad;
    logic        r_rd_ok;
    logic        r_wr_ok;
    logic        r_last;
    logic [15:0] r_sh;

    logic        w_rise, w_fall, w_bit;
    logic [4:0]  w_phyad_full, w_regad_full;

    assign w_rise       = r_mdc_s2 & ~r_mdc_d;
    assign w_fall       = ~r_mdc_s2 & r_mdc_d;
    assign w_bit        = r_mdio_s2;
    assign w_phyad_full = {r_phyad, w_bit};
    assign w_regad_full = {r_regad, w_bit};

    // Bring MDC and MDIO into the system clock domain and keep a delayed MDC for edges
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mdc_s1  <= 1'b0;
            r_mdc_s2  <= 1'b0;
            r_mdc_d   <= 1'b0;
            r_mdio_s1 <= 1'b0;
            r_mdio_s2 <= 1'b0;
        end else begin
            r_mdc_s1  <= mdc;
            r_mdc_s2  <= r_mdc_s1;
            r_mdc_d   <= r_mdc_s2;
            r_mdio_s1 <= mdio_in;
            r_mdio_s2 <= r_mdio_s1;
        end
    end

    // Frame decoder: sample on MDC rise, drive the bus on MDC fall
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= S_PRE;
            r_pre_cnt <= 6'd0;
            r_bit_cnt <= 5'd0;
            r_op      <= 2'b00;
            r_phyad   <= 4'd0;
            r_regad   <= 4'd0;
            r_rd_ok   <= 1'b0;
            r_wr_ok   <= 1'b0;
            r_last    <= 1'b0;
            r_sh      <= 16'd0;
            mdio_out  <= 1'b0;
            mdio_oen  <= 1'b1;
            reg_addr  <= 5'd0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= 16'd0;
        end else begin
            reg_rd <= 1'b0;
            reg_wr <= 1'b0;
            // user logic answers one clk after the request
            if (reg_rd) begin
                r_sh <= reg_rdata;
            end
            if (w_rise) begin
                case (r_state)
                    S_PRE: begin
                        if (w_bit) begin
                            if (r_pre_cnt != L_PRE_MIN) begin
                                r_pre_cnt <= r_pre_cnt + 6'd1;
                            end
                        end else if (r_pre_cnt == L_PRE_MIN) begin
                            r_pre_cnt <= 6'd0;
                            r_state   <= S_ST;
                        end else begin
                            r_pre_cnt <= 6'd0;
                        end
                    end
                    S_ST: begin
                        r_bit_cnt <= 5'd0;
                        r_pre_cnt <= 6'd0;
                        r_state   <= w_bit ? S_OP : S_PRE;
                    end
                    S_OP: begin
                        r_op <= {r_op[0], w_bit};
                        if (r_bit_cnt == 5'd1) begin
                            r_bit_cnt <= 5'd0;
                            r_state   <= S_PHYAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    S_PHYAD: begin
                        r_phyad <= w_phyad_full[3:0];
                        if (r_bit_cnt == 5'd4) begin
                            // PHYAD 0 is broadcast for writes only, never answered on reads
                            r_rd_ok   <= (r_op == 2'b10) && (w_phyad_full == PHY_ADDR)
                                         && (w_phyad_full != 5'd0);
                            r_wr_ok   <= (r_op == 2'b01) && ((w_phyad_full == PHY_ADDR)
                                         || (BROADCAST_EN && (w_phyad_full == 5'd0)));
                            r_bit_cnt <= 5'd0;
                            r_state   <= S_REGAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        r_regad <= w_regad_full[3:0];
                        if (r_bit_cnt == 5'd4) begin
                            reg_addr  <= w_regad_full;
                            reg_rd    <= r_rd_ok;
                            r_bit_cnt <= 5'd0;
                            r_state   <= S_TA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    S_TA: begin
                        if (r_bit_cnt == 5'd1) begin
                            r_bit_cnt <= 5'd0;
                            r_last    <= 1'b0;
                            r_state   <= S_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    S_DATA: begin
                        if (r_rd_ok) begin
                            // read leaves DATA on the fall after the 16th bit
                            if (r_bit_cnt == 5'd15) begin
                                r_last <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else begin
                            if (r_wr_ok) begin
                                r_sh <= {r_sh[14:0], w_bit};
                            end
                            if (r_bit_cnt == 5'd15) begin
                                if (r_wr_ok) begin
                                    reg_wr    <= 1'b1;
                                    reg_wdata <= {r_sh[14:0], w_bit};
                                end
                                r_bit_cnt <= 5'd0;
                                r_pre_cnt <= 6'd0;
                                r_state   <= S_PRE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_pre_cnt <= 6'd0;
                        r_state   <= S_PRE;
                    end
                endcase
            end else if (w_fall) begin
                if ((r_state == S_TA) && (r_bit_cnt == 5'd1) && r_rd_ok) begin
                    mdio_oen <= 1'b0;
                    mdio_out <= 1'b0;
                end else if ((r_state == S_DATA) && r_rd_ok) begin
                    if (r_last) begin
                        mdio_oen  <= 1'b1;
                        mdio_out  <= 1'b0;
                        r_last    <= 1'b0;
                        r_rd_ok   <= 1'b0;
                        r_bit_cnt <= 5'd0;
                        r_pre_cnt <= 6'd0;
                        r_state   <= S_PRE;
                    end else begin
                        mdio_out <= r_sh[15];
                        r_sh     <= {r_sh[14:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
